mdu_seq_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle ALU.
- Runs an iterative shift-add unsigned multiply or a restoring unsigned divide, one bit per clock.
- Uses a start/busy/done handshake toward the CPU control unit.
- Registers hi/lo results and a zero flag computed as an OR-reduction over lo.

---
 rtl/mdu_seq_ctrl_if.sv | 32 +++
 rtl/mdu_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl_if
// Handshake and result bundle between the CPU control unit and the
// multiply/divide sequencer.
//   master : CPU side   -- drives start, op, a, b; observes status/results
//   slave  : MDU side   -- observes request; drives busy, done, hi, lo,
//                          zero, div_by_zero
// ---------------------------------------------------------------------------
interface mdu_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             zero;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, zero, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, zero, div_by_zero
   );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl
// Multi-cycle sequencer for unsigned multiply (shift-add) and unsigned
// divide (restoring), one result bit per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : mdu_seq_ctrl_if.slave
//          start/op/a/b sampled only in IDLE
//          busy high in CALC and DONE, done is a one-cycle pulse
//          hi/lo = product upper/lower, or remainder/quotient
//          zero = (lo == 0), div_by_zero = last divide had b == 0
// ---------------------------------------------------------------------------
module mdu_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   mdu_seq_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             first, first_n;
   logic             op_r, op_n;
   logic [WIDTH-1:0] a_r, a_n;
   logic [WIDTH-1:0] b_r, b_n;
   logic [WIDTH-1:0] hi_r, hi_n;
   logic [WIDTH-1:0] lo_r, lo_n;
   logic             zero_r, zero_n;
   logic             dbz_r, dbz_n;

   // One multiply iteration: conditional add into hi with carry, then
   // shift {carry, hi, lo} right by one.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo_r[WIDTH-1:1]};

   // One restoring-divide iteration. The shifted remainder needs one extra
   // bit; once the subtraction is taken the difference is below b, so the
   // low WIDTH bits of the difference are exact.
   logic [WIDTH:0]   div_rsh;
   logic [WIDTH-1:0] div_qsh;
   logic             div_ge;
   logic [WIDTH-1:0] div_hi, div_lo;

   assign div_rsh = {hi_r, lo_r[WIDTH-1]};
   assign div_qsh = {lo_r[WIDTH-2:0], 1'b0};
   assign div_ge  = (div_rsh >= {1'b0, b_r});
   assign div_hi  = div_ge ? (div_rsh[WIDTH-1:0] - b_r) : div_rsh[WIDTH-1:0];
   assign div_lo  = div_ge ? (div_qsh | {{(WIDTH-1){1'b0}}, 1'b1}) : div_qsh;

   logic [WIDTH-1:0] step_hi, step_lo;

   assign step_hi = op_r ? div_hi : mul_hi;
   assign step_lo = op_r ? div_lo : mul_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         first  <= 1'b0;
         op_r   <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
         zero_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         first  <= first_n;
         op_r   <= op_n;
         a_r    <= a_n;
         b_r    <= b_n;
         hi_r   <= hi_n;
         lo_r   <= lo_n;
         zero_r <= zero_n;
         dbz_r  <= dbz_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      first_n = first;
      op_n    = op_r;
      a_n     = a_r;
      b_n     = b_r;
      hi_n    = hi_r;
      lo_n    = lo_r;
      zero_n  = zero_r;
      dbz_n   = dbz_r;

      case (state)
         IDLE: begin
            if (bus.start) begin
               op_n    = bus.op;
               a_n     = bus.a;
               b_n     = bus.b;
               dbz_n   = 1'b0;
               cnt_n   = CNT_W'(WIDTH);
               first_n = 1'b1;
               state_n = CALC;
            end
         end

         CALC: begin
            if (first) begin
               // First CALC cycle loads the working registers from the
               // latched operands; a zero divisor short-circuits here.
               first_n = 1'b0;
               if (op_r && (b_r == '0)) begin
                  hi_n    = a_r;
                  lo_n    = '1;
                  dbz_n   = 1'b1;
                  zero_n  = 1'b0;
                  state_n = DONE;
               end else begin
                  hi_n = '0;
                  lo_n = a_r;
               end
            end else begin
               hi_n  = step_hi;
               lo_n  = step_lo;
               cnt_n = cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  zero_n  = ~(|step_lo);
                  state_n = DONE;
               end
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
   assign bus.zero        = zero_r;
   assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq_ctrl
// Self-checking bench for mdu_seq_ctrl: directed cases with literal results
// plus randomized operations checked every cycle against a transaction-level
// model (results from plain * / %, latency from the documented timing).
// ---------------------------------------------------------------------------
module tb_mdu_seq_ctrl;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mdu_seq_ctrl_if #(.WIDTH(W)) bus ();

   mdu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_left = busy cycles still to come (including the current one);
   // the done cycle is the last busy cycle, where results appear.
   int          m_left;
   logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
   logic        m_zero, m_dbz, p_dbz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_zero <= 1'b0;
         m_dbz  <= 1'b0;
         p_hi   <= '0;
         p_lo   <= '0;
         p_dbz  <= 1'b0;
      end else if (m_left == 0) begin
         if (bus.start) begin
            m_dbz <= 1'b0;
            if (bus.op && bus.b == '0) begin
               m_left <= 2;
               p_hi   <= bus.a;
               p_lo   <= '1;
               p_dbz  <= 1'b1;
            end else begin
               m_left <= W + 2;
               p_dbz  <= 1'b0;
               if (bus.op) begin
                  p_hi <= bus.a % bus.b;
                  p_lo <= bus.a / bus.b;
               end else begin
                  p_hi <= W'((64'(bus.a) * 64'(bus.b)) >> W);
                  p_lo <= W'(64'(bus.a) * 64'(bus.b));
               end
            end
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 2) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_zero <= (p_lo == '0);
            m_dbz  <= p_dbz;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(bus.busy), 64'(m_left > 0));
         chk("done", 64'(bus.done), 64'(m_left == 1));
         if (m_left <= 1) begin
            chk("hi",   64'(bus.hi), 64'(m_hi));
            chk("lo",   64'(bus.lo), 64'(m_lo));
            chk("zero", 64'(bus.zero), 64'(m_zero));
            chk("dbz",  64'(bus.div_by_zero), 64'(m_dbz));
         end
         if (bus.done) done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   // Pulse start for one accept edge, then wait (bounded) for done.
   // inj > 0 pulses a second start with a=b=1 at that busy cycle.
   // noise wiggles a/b/start while busy.
   task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit noise, input int inj, input bit pin,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic ez, input logic edz, input string nm);
      int n;
      int lat;
      bit seen;
      lat = (o && y == '0) ? 2 : W + 2;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      seen = 1'b0;
      while (n < 100 && !seen) begin
         @(negedge clk);
         n++;
         if (bus.done) seen = 1'b1;
         else if (n == inj) begin
            bus.start = 1'b1; bus.a = 1; bus.b = 1;
         end else if (noise) begin
            bus.a = $urandom; bus.b = $urandom;
            bus.op = 1'($urandom_range(0, 1));
            bus.start = ($urandom_range(0, 3) == 0);
         end else begin
            bus.start = 1'b0;
         end
      end
      // a start still high at the DONE-exit edge must be ignored
      chk({nm, "_latency"}, 64'(n), 64'(lat));
      if (pin) begin
         chk({nm, "_hi"},   64'(bus.hi), 64'(ehi));
         chk({nm, "_lo"},   64'(bus.lo), 64'(elo));
         chk({nm, "_zero"}, 64'(bus.zero), 64'(ez));
         chk({nm, "_dbz"},  64'(bus.div_by_zero), 64'(edz));
         chk({nm, "_model_lo"}, 64'(m_lo), 64'(elo));
         chk({nm, "_model_hi"}, 64'(m_hi), 64'(ehi));
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic o;
      logic [W-1:0] x, y;

      bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_lo",   64'(bus.lo), 64'd0);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      run_op(0, 7, 6, 0, 0, 1, 0, 42, 0, 0, "mul_7x6");
      run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFE, 32'h1, 0, 0, "mul_max");
      run_op(0, 0, 123, 0, 0, 1, 0, 0, 1, 0, "mul_zero");
      run_op(1, 100, 7, 0, 0, 1, 2, 14, 0, 0, "div_100_7");
      run_op(1, 3, 10, 0, 0, 1, 3, 0, 1, 0, "div_3_10");
      run_op(1, 5, 0, 0, 0, 1, 5, 32'hFFFFFFFF, 0, 1, "div_by_0");
      run_op(0, 2, 3, 0, 0, 1, 0, 6, 0, 0, "mul_after_dbz");

      d0 = done_cnt;
      run_op(0, 9, 9, 0, 10, 1, 0, 81, 0, 0, "busy_reject");
      repeat (40) @(posedge clk);
      chk("busy_reject_done_count", 64'(done_cnt - d0), 64'd1);

      // reset in the middle of a multiply
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h1234; bus.b = 32'h5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_done", 64'(bus.done), 64'd0);
      chk("midrst_hi",   64'(bus.hi), 64'd0);
      chk("midrst_lo",   64'(bus.lo), 64'd0);
      chk("midrst_zero", 64'(bus.zero), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run_op(0, 1000, 1000, 0, 0, 1, 0, 1000000, 0, 0, "after_rst");

      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom_range(0, 1));
         x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
         case ($urandom_range(0, 7))
            0:       y = '0;
            1:       y = W'($urandom_range(1, 15));
            default: y = W'($urandom);
         endcase
         run_op(o, x, y, 1, 0, 0, '0, '0, 1'b0, 1'b0, "rand");
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
